// File: rtl/shield_sprite_fetch.sv
// Shield overlay pixel fetch: hit test against the latched tank position, sprite ROM
// addressing, a 3-cycle pixel pipeline and the shield lifetime/blink timer.
// Define SHIELD_ANIM_EN to add a two-frame animation bit as the rom_addr MSB.
module shield_sprite_fetch #(
    parameter int SPRITE_W     = 32,
    parameter int SPRITE_H     = 32,
    parameter int ADDR_W       = 10,
    parameter int LIFE_FRAMES  = 600,
    parameter int BLINK_FRAMES = 120,
    parameter int BLINK_PERIOD = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              activate,
    input  logic [9:0]        tank_x,
    input  logic [9:0]        tank_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
`ifdef SHIELD_ANIM_EN
    output logic [ADDR_W:0]   rom_addr,
`else
    output logic [ADDR_W-1:0] rom_addr,
`endif
    input  logic [7:0]        rom_data,
    output logic [7:0]        pix_index,
    output logic              pix_valid,
    output logic              shield_on,
    output logic [9:0]        frames_left
);

    localparam int XW = $clog2(SPRITE_W);
    localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_BLINK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [9:0]    r_frames_left;
    logic [9:0]    w_frames_nxt;
    logic [9:0]    w_frames_dec;
    logic [BW-1:0] r_blink_cnt;
    logic [BW-1:0] w_blink_nxt;
    logic          r_hidden;
    logic          w_hidden_nxt;
    logic          r_shield_on;

    logic [9:0]    r_lx;
    logic [9:0]    r_ly;

    logic [10:0]       w_rel_x;
    logic [10:0]       w_rel_y;
    logic              w_hit;
    logic              w_visible;
    logic [ADDR_W-1:0] w_offset;

`ifdef SHIELD_ANIM_EN
    logic [ADDR_W:0]   r_rom_addr;
    logic [3:0]        r_anim_cnt;
    logic              r_anim;
`else
    logic [ADDR_W-1:0] r_rom_addr;
`endif
    logic              r_hit_d1;
    logic              r_vis_d1;
    logic              r_hit_d2;
    logic              r_vis_d2;
    logic [7:0]        r_pix_index;
    logic              r_pix_valid;

    // Position is sampled only at vertical blank so a moving tank never tears the sprite.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_lx <= '0;
            r_ly <= '0;
        end else if (frame_start) begin
            r_lx <= tank_x;
            r_ly <= tank_y;
        end
    end

    // The 11-bit difference keeps left/top clipped sprites out of the wrapped range,
    // so a negative offset can never compare as an in-sprite coordinate.
    assign w_rel_x  = {1'b0, DrawX} - {1'b0, r_lx} + 11'(SPRITE_W / 2);
    assign w_rel_y  = {1'b0, DrawY} - {1'b0, r_ly} + 11'(SPRITE_H / 2);
    assign w_hit    = (w_rel_x < 11'(SPRITE_W)) && (w_rel_y < 11'(SPRITE_H));
    assign w_offset = (ADDR_W'(w_rel_y) << XW) | ADDR_W'(w_rel_x[XW-1:0]);

    assign w_visible = (r_state == S_ACTIVE) || ((r_state == S_BLINK) && !r_hidden);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= S_IDLE;
            r_frames_left <= '0;
            r_blink_cnt   <= '0;
            r_hidden      <= 1'b0;
            r_shield_on   <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all of them update from pre-edge values.
            r_state       <= w_state_nxt;
            r_frames_left <= w_frames_nxt;
            r_blink_cnt   <= w_blink_nxt;
            r_hidden      <= w_hidden_nxt;
            r_shield_on   <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_nxt  = r_state;
        w_frames_nxt = r_frames_left;
        w_blink_nxt  = r_blink_cnt;
        w_hidden_nxt = r_hidden;
        w_frames_dec = r_frames_left - 10'd1;

        if (activate) begin
            w_state_nxt  = S_ACTIVE;
            w_frames_nxt = 10'(LIFE_FRAMES);
            w_blink_nxt  = '0;
            w_hidden_nxt = 1'b0;
        end else if (frame_start && (r_state != S_IDLE)) begin
            w_frames_nxt = w_frames_dec;
            if (r_state == S_BLINK) begin
                if (r_blink_cnt == BW'(BLINK_PERIOD - 1)) begin
                    w_blink_nxt  = '0;
                    w_hidden_nxt = !r_hidden;
                end else begin
                    w_blink_nxt = r_blink_cnt + BW'(1);
                end
            end
            if (w_frames_dec == 10'd0) begin
                w_state_nxt = S_IDLE;
            end else if ((r_state == S_ACTIVE) && (w_frames_dec <= 10'(BLINK_FRAMES))) begin
                w_state_nxt  = S_BLINK;
                w_blink_nxt  = '0;
                w_hidden_nxt = 1'b0;
            end
        end
    end

`ifdef SHIELD_ANIM_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_anim_cnt <= '0;
            r_anim     <= 1'b0;
        end else if (activate) begin
            r_anim_cnt <= '0;
            r_anim     <= 1'b0;
        end else if (frame_start && r_shield_on) begin
            r_anim_cnt <= r_anim_cnt + 4'd1;
            if (r_anim_cnt == 4'd15) begin
                r_anim <= !r_anim;
            end
        end
    end
`endif

    // Stage 1: address and qualifiers; the address holds on a miss to avoid needless ROM toggling.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= '0;
            r_hit_d1   <= 1'b0;
            r_vis_d1   <= 1'b0;
        end else begin
            r_hit_d1 <= w_hit;
            r_vis_d1 <= w_visible;
            if (w_hit) begin
`ifdef SHIELD_ANIM_EN
                r_rom_addr <= {r_anim, w_offset};
`else
                r_rom_addr <= w_offset;
`endif
            end
        end
    end

    // Stage 2 waits out the ROM read; stage 3 samples its data, index 0 being transparent.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hit_d2    <= 1'b0;
            r_vis_d2    <= 1'b0;
            r_pix_index <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_hit_d2    <= r_hit_d1;
            r_vis_d2    <= r_vis_d1;
            r_pix_index <= rom_data;
            r_pix_valid <= r_hit_d2 && r_vis_d2 && (rom_data != 8'd0);
        end
    end

    assign rom_addr    = r_rom_addr;
    assign pix_index   = r_pix_index;
    assign pix_valid   = r_pix_valid;
    assign shield_on   = r_shield_on;
    assign frames_left = r_frames_left;

endmodule

// File: tb/tb_shield_sprite_fetch.sv
// Randomized bench for shield_sprite_fetch against a frame-count reference model
// with a behavioural synchronous ROM.
module tb_shield_sprite_fetch;

    localparam int SPRITE_W     = 32;
    localparam int SPRITE_H     = 32;
    localparam int LIFE_FRAMES  = 600;
    localparam int BLINK_FRAMES = 120;
    localparam int BLINK_PERIOD = 8;
`ifdef SHIELD_ANIM_EN
    localparam int RA_W = 11;
`else
    localparam int RA_W = 10;
`endif

    logic            Clk;
    logic            Reset_n;
    logic            frame_start;
    logic            activate;
    logic [9:0]      tank_x;
    logic [9:0]      tank_y;
    logic [9:0]      DrawX;
    logic [9:0]      DrawY;
    logic [RA_W-1:0] rom_addr;
    logic [7:0]      rom_data;
    logic [7:0]      pix_index;
    logic            pix_valid;
    logic            shield_on;
    logic [9:0]      frames_left;

    shield_sprite_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .activate    (activate),
        .tank_x      (tank_x),
        .tank_y      (tank_y),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_index   (pix_index),
        .pix_valid   (pix_valid),
        .shield_on   (shield_on),
        .frames_left (frames_left)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Sprite contents: every 7th texel transparent, the rest a scrambled index.
    function automatic logic [7:0] rom_f(int a);
        if (a % 7 == 0) return 8'd0;
        return 8'((a * 37 + 11) & 255);
    endfunction

    always_ff @(posedge Clk) rom_data <= rom_f(int'(rom_addr[9:0]));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit is_real;
        bit hit;
        bit vis;
        int addr;
    } px_t;

    px_t pipe[$];
    int  m_left;
    int  m_lx;
    int  m_ly;
    int  m_addr;

    // Blink phase follows from how many frames have elapsed since lifetime hit BLINK_FRAMES.
    function automatic bit m_visible(int left);
        if (left > BLINK_FRAMES) return 1'b1;
        if (left == 0) return 1'b0;
        return (((BLINK_FRAMES - left) / BLINK_PERIOD) % 2) == 0;
    endfunction

    task automatic model_reset();
        px_t d;
        m_left = 0;
        m_lx   = 0;
        m_ly   = 0;
        m_addr = 0;
        d.is_real = 1'b0;
        d.hit     = 1'b0;
        d.vis     = 1'b0;
        d.addr    = 0;
        pipe.delete();
        pipe.push_back(d);
        pipe.push_back(d);
    endtask

    task automatic cycle();
        int  rx, ry, na, nl;
        bit  hit, vis;
        px_t e, o;
        rx  = int'(DrawX) - m_lx + SPRITE_W / 2;
        ry  = int'(DrawY) - m_ly + SPRITE_H / 2;
        hit = (rx >= 0) && (rx < SPRITE_W) && (ry >= 0) && (ry < SPRITE_H);
        vis = m_visible(m_left);
        na  = hit ? (ry * SPRITE_W + rx) : m_addr;
        nl  = m_left;
        if (activate) nl = LIFE_FRAMES;
        else if (frame_start && m_left > 0) nl = m_left - 1;
        if (frame_start) begin
            m_lx = int'(tank_x);
            m_ly = int'(tank_y);
        end
        @(posedge Clk);
        #1;
        m_left      = nl;
        m_addr      = na;
        frame_start = 1'b0;
        activate    = 1'b0;
        check("rom_addr", int'(rom_addr[9:0]), m_addr);
        check("frames_left", int'(frames_left), m_left);
        check("shield_on", int'(shield_on), int'(m_left > 0));
        e.is_real = 1'b1;
        e.hit     = hit;
        e.vis     = vis;
        e.addr    = na;
        pipe.push_back(e);
        if (pipe.size() >= 3) begin
            o = pipe.pop_front();
            if (o.is_real) begin
                check("pix_index", int'(pix_index), int'(rom_f(o.addr)));
                check("pix_valid", int'(pix_valid), int'(o.hit && o.vis && (rom_f(o.addr) != 8'd0)));
            end else begin
                check("pix_valid_flush", int'(pix_valid), 0);
            end
        end
    endtask

    task automatic px_near();
        DrawX = 10'((m_lx + int'($urandom_range(0, 44)) - 22) & 1023);
        DrawY = 10'((m_ly + int'($urandom_range(0, 44)) - 22) & 1023);
        if ($urandom_range(0, 7) == 0) DrawX = 10'($urandom_range(0, 1023));
    endtask

    task automatic px_center();
        DrawX = 10'(m_lx);
        DrawY = 10'(m_ly);
    endtask

    task automatic run_frames(int n);
        for (int f = 0; f < n; f++) begin
            frame_start = 1'b1;
            px_near();
            cycle();
            for (int k = 0; k < 3; k++) begin
                px_near();
                cycle();
            end
        end
    endtask

    // Asserted between clock edges: outputs must clear without waiting for a clock.
    task automatic apply_reset();
        #2 Reset_n = 1'b0;
        #1;
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_frames_left", int'(frames_left), 0);
        check("rst_shield_on", int'(shield_on), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_pix_index", int'(pix_index), 0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n     = 1'b1;
        frame_start = 1'b0;
        activate    = 1'b0;
        tank_x      = '0;
        tank_y      = '0;
        DrawX       = '0;
        DrawY       = '0;
        apply_reset();

        // Centred sprite: top-left texel, then one pixel right of the sprite.
        tank_x = 10'd320;
        tank_y = 10'd240;
        frame_start = 1'b1;
        px_near();
        cycle();
        activate = 1'b1;
        cycle();
        DrawX = 10'd304;
        DrawY = 10'd224;
        cycle();
        check("tp_addr0", int'(rom_addr), 0);
        DrawX = 10'd336;
        repeat (3) cycle();
        check("tp_miss_right", int'(pix_valid), 0);

        // Clipped at the top-left screen corner.
        tank_x = 10'd5;
        tank_y = 10'd5;
        frame_start = 1'b1;
        cycle();
        DrawX = 10'd1020;
        DrawY = 10'd0;
        cycle();
        DrawX = 10'd0;
        cycle();
        check("clip_addr", int'(rom_addr), 363);
        DrawX = 10'd1020;
        repeat (3) cycle();
        check("clip_no_alias", int'(pix_valid), 0);

        // Full lifetime including the blink window.
        tank_x = 10'd320;
        tank_y = 10'd240;
        activate = 1'b1;
        px_near();
        cycle();
        run_frames(480);
        check("life_blink_left", int'(frames_left), 120);
        run_frames(8);
        px_center();
        repeat (4) cycle();
        check("blink_hidden", int'(pix_valid), 0);
        run_frames(112);
        check("life_end_on", int'(shield_on), 0);
        check("life_end_left", int'(frames_left), 0);

        // Activate coincident with frame_start late in life.
        activate = 1'b1;
        cycle();
        run_frames(550);
        check("pre_left50", int'(frames_left), 50);
        tank_x = 10'd100;
        tank_y = 10'd200;
        activate = 1'b1;
        frame_start = 1'b1;
        cycle();
        check("act_wins_left", int'(frames_left), 600);
        check("act_wins_on", int'(shield_on), 1);
        px_center();
        repeat (4) cycle();
        check("new_pos_hit", int'(pix_valid), 1);

        // Moving the tank mid-frame must not shift the hit region.
        tank_x = 10'd700;
        repeat (4) cycle();
        check("no_tear", int'(pix_valid), 1);
        apply_reset();

        // Random mix of frames, re-activations and tank moves.
        activate = 1'b1;
        px_near();
        cycle();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) frame_start = 1'b1;
            if ($urandom_range(0, 399) == 0) activate = 1'b1;
            if ($urandom_range(0, 49) == 0) begin
                tank_x = 10'($urandom_range(0, 1023));
                tank_y = 10'($urandom_range(0, 1023));
            end
            px_near();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/shield_sprite_fetch.md
Name: shield_sprite_fetch

Overview:
- Upstream pixel stage for the shield overlay. Per VGA pixel, decides whether (DrawX, DrawY) falls inside the shield sprite centred on the tank.
- Generates the address for the synchronous shield sprite ROM and returns the 8-bit palette index, with a valid flag, to the shield palette lookup.
- Owns the shield lifetime timer, including end-of-life blinking, so the compositor only consumes pix_index/pix_valid.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of 2).
- SPRITE_H, 32, sprite height in pixels.
- ADDR_W, 10, ROM address width (log2(SPRITE_W*SPRITE_H)).
- LIFE_FRAMES, 600, shield lifetime in frames after activation.
- BLINK_FRAMES, 120, final frames in which the shield blinks.
- BLINK_PERIOD, 8, frames per blink half-period.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- activate  in  1  one-cycle pulse; (re)starts the shield.
- tank_x  in  10  tank centre X.
- tank_y  in  10  tank centre Y.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- rom_addr  out  ADDR_W  sprite ROM address, registered.
- rom_data  in  8  ROM output, valid one cycle after rom_addr.
- pix_index  out  8  palette index to the palette stage.
- pix_valid  out  1  shield pixel is opaque and must be drawn.
- shield_on  out  1  shield state is ACTIVE or BLINK.
- frames_left  out  10  remaining lifetime in frames.

Behaviour:
- Reset (async, Reset_n=0) clears all outputs and state:
  - rom_addr=0, pix_index=0, pix_valid=0, shield_on=0, frames_left=0.
  - State=IDLE, latched position=0, blink counter=0, phase=visible.
- Position latch:
  - tank_x/tank_y are captured into lx/ly only on frame_start, so there is no mid-frame tearing.
  - The latch happens regardless of state.
- Hit test, cycle t (DrawX/DrawY sampled):
  - rel_x = DrawX - lx + SPRITE_W/2 and rel_y = DrawY - ly + SPRITE_H/2, computed in 11-bit signed arithmetic.
  - hit = 0<=rel_x<SPRITE_W and 0<=rel_y<SPRITE_H.
  - Sprites clipped at screen edges (lx<16 etc.) must never alias.
- Pipeline:
  - t+1: rom_addr = rel_y*SPRITE_W + rel_x (a shift, no multiplier). hit_d1 is registered. On a miss, rom_addr holds its previous value.
  - t+2: rom_data is valid. hit_d2 is registered.
  - t+3: pix_index <= rom_data. pix_valid <= hit_d2 & visible_d2 & (rom_data != 0).
  - Index 0 is transparent.
  - Total latency DrawX -> pix_index is 3 cycles and is fixed; the compositor delays DrawX to match.
- visible = (state==ACTIVE) | (state==BLINK & phase==visible).
  - It is sampled at t and pipelined alongside hit.
- State machine IDLE / ACTIVE / BLINK:
  - activate (any state): frames_left <= LIFE_FRAMES, state <= ACTIVE, blink counter <= 0, phase <= visible.
  - activate and frame_start in the same cycle: activate wins, with no decrement. The position latch still occurs.
  - frame_start in ACTIVE/BLINK: frames_left <= frames_left-1.
    - If the new value is 0: state <= IDLE.
    - Else if the new value is <= BLINK_FRAMES: state <= BLINK.
  - frame_start in IDLE: no change to the timer.
  - BLINK: the blink counter increments on each frame_start. At BLINK_PERIOD-1 it wraps to 0 and phase toggles. On BLINK entry the counter=0 and phase=visible.
  - shield_on is a registered decode of state.
- Reset mid-frame: the pipeline flushes, so pix_valid=0 immediately (async). The first valid pixel can appear no earlier than 3 cycles after Reset_n release.

Optional Feature:
- Macro: SHIELD_ANIM_EN.
- When defined, the ROM holds 2 animation frames:
  - rom_addr widens to ADDR_W+1.
  - The MSB is an animation bit that toggles on every 16th frame_start while shield_on=1.
  - The bit resets to 0 on activate and on reset.
- When undefined:
  - rom_addr is ADDR_W wide and there is no animation bit.
  - Timing and all other behaviour are identical.

Test Plan:
- Reset then activate, tank=(320,240), DrawX=304, DrawY=224 -> rom_addr=0 at t+1; pix_index=rom_data(0) at t+3; pix_valid=1 if data!=0. DrawX=336 -> pix_valid=0 (rel_x=32).
- Edge clip: tank=(5,5), DrawX=1020, DrawY=0 -> pix_valid=0. DrawX=0, DrawY=0 -> rom_addr=11*32+11=363.
- Lifetime: activate, then 480 frame_start pulses -> frames_left=120, state=BLINK, visible. After 8 more -> phase invisible, pix_valid=0. After 600 total -> shield_on=0, frames_left=0.
- Same-cycle activate+frame_start at frames_left=50 -> frames_left=600, state=ACTIVE, new tank position latched.
- tank_x changed mid-frame -> hit region unchanged until the next frame_start.
- Reset_n asserted mid-line with pix_valid=1 -> pix_valid=0 and frames_left=0 immediately. With SHIELD_ANIM_EN: rom_addr MSB toggles after 16 frames.
